// File: rtl/clause_bin_loader.sv
// Clause bin loader: moves clause words between bin memory and the
// clause array through its one-hot load/update strobes.
module clause_bin_loader #(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_CNT   = 4,
    parameter int WIDTH_ADDR  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_load_i,
    input  logic                            start_unload_i,
    input  logic [WIDTH_ADDR-1:0]           base_addr_i,
    input  logic [WIDTH_CNT-1:0]            num_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            mem_rd_o,
    output logic [WIDTH_ADDR-1:0]           mem_addr_o,
    input  logic [NUM_VARS*2+WIDTH_C_LEN-1:0] mem_rdata_i,
    input  logic                            mem_rvalid_i,
    output logic                            mem_wr_o,
    output logic [NUM_VARS*2+WIDTH_C_LEN-1:0] mem_wdata_o,
    input  logic                            mem_wready_i,
    output logic [NUM_CLAUSES-1:0]          wr_o,
    output logic [NUM_CLAUSES-1:0]          rd_o,
    output logic [NUM_VARS*2-1:0]           clause_o,
    output logic [WIDTH_C_LEN-1:0]          clause_len_o,
    input  logic [NUM_VARS*2-1:0]           clause_i
);

    localparam int LW = NUM_VARS * 2;
    localparam int WW = LW + WIDTH_C_LEN;
    localparam int IW = $clog2(NUM_CLAUSES + 1);

    typedef enum logic [3:0] {
        IDLE, LD_REQ, LD_WAIT, LD_WR, LD_ZERO,
        UL_RD, UL_CAP, UL_WR, DONE
    } state_t;

    state_t                  state, state_d;
    logic [WIDTH_ADDR-1:0]   base, base_d;
    logic [IW-1:0]           n, n_d, idx, idx_d;
    logic [IW-1:0]           idx_inc, n_cap;
    logic [LW-1:0]           lits, lits_d;
    logic [WIDTH_C_LEN-1:0]  len, len_d;

    logic                    busy_d, done_d, mem_rd_d, mem_wr_d;
    logic [WIDTH_ADDR-1:0]   mem_addr_d;
    logic [WW-1:0]           mem_wdata_d;
    logic [NUM_CLAUSES-1:0]  wr_d, rd_d;
    logic [LW-1:0]           clause_d;
    logic [WIDTH_C_LEN-1:0]  clause_len_d;

    // Any nonzero 2-bit field is a present literal; saturate the count.
    function automatic logic [WIDTH_C_LEN-1:0] lit_count(input logic [LW-1:0] l);
        int c;
        c = 0;
        for (int k = 0; k < NUM_VARS; k++) begin
            if (l[2*k +: 2] != 2'b00) c++;
        end
        if (c > (1 << WIDTH_C_LEN) - 1) return '1;
        return WIDTH_C_LEN'(c);
    endfunction

    assign idx_inc = idx + 1'b1;
    assign n_cap   = ({{(32-WIDTH_CNT){1'b0}}, num_i} > 32'(NUM_CLAUSES))
                   ? IW'(NUM_CLAUSES) : IW'(num_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            base  <= '0;
            n     <= '0;
            idx   <= '0;
            lits  <= '0;
            len   <= '0;
        end else begin
            state <= state_d;
            base  <= base_d;
            n     <= n_d;
            idx   <= idx_d;
            lits  <= lits_d;
            len   <= len_d;
        end
    end

    always_comb begin
        state_d = state;
        base_d  = base;
        n_d     = n;
        idx_d   = idx;
        lits_d  = lits;
        len_d   = len;
        unique case (state)
            IDLE: begin
                if (start_load_i) begin
                    base_d  = base_addr_i;
                    n_d     = n_cap;
                    idx_d   = '0;
                    state_d = (n_cap == '0) ? LD_ZERO : LD_REQ;
                end else if (start_unload_i) begin
                    base_d  = base_addr_i;
                    n_d     = n_cap;
                    idx_d   = '0;
                    state_d = (n_cap == '0) ? DONE : UL_RD;
                end
            end
            LD_REQ:  state_d = LD_WAIT;
            LD_WAIT: begin
                if (mem_rvalid_i) begin
                    lits_d  = mem_rdata_i[LW-1:0];
                    len_d   = mem_rdata_i[WW-1:LW];
                    state_d = LD_WR;
                end
            end
            LD_WR: begin
                idx_d = idx_inc;
                if (idx_inc < n)                     state_d = LD_REQ;
                else if (idx_inc < IW'(NUM_CLAUSES)) state_d = LD_ZERO;
                else                                 state_d = DONE;
            end
            LD_ZERO: begin
                idx_d   = idx_inc;
                state_d = (idx_inc < IW'(NUM_CLAUSES)) ? LD_ZERO : DONE;
            end
            UL_RD:  state_d = UL_CAP;
            UL_CAP: begin
                lits_d  = clause_i;
                len_d   = lit_count(clause_i);
                state_d = UL_WR;
            end
            UL_WR: begin
                if (mem_wready_i) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc < n) ? UL_RD : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        busy_d       = (state_d != IDLE) && (state_d != DONE);
        done_d       = (state_d == DONE);
        mem_rd_d     = (state_d == LD_REQ);
        mem_wr_d     = (state_d == UL_WR);
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        wr_d         = '0;
        rd_d         = '0;
        clause_d     = '0;
        clause_len_d = '0;
        if (state_d == LD_REQ || state_d == UL_WR)
            mem_addr_d = base_d + WIDTH_ADDR'(idx_d);
        if (state_d == UL_WR)
            mem_wdata_d = {len_d, lits_d};
        if (state_d == LD_WR || state_d == LD_ZERO)
            wr_d = NUM_CLAUSES'(1) << idx_d;
        if (state_d == LD_WR) begin
            clause_d     = lits_d;
            clause_len_d = len_d;
        end
        if (state_d == UL_RD)
            rd_d = NUM_CLAUSES'(1) << idx_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            mem_rd_o     <= 1'b0;
            mem_wr_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            wr_o         <= '0;
            rd_o         <= '0;
            clause_o     <= '0;
            clause_len_o <= '0;
        end else begin
            busy_o       <= busy_d;
            done_o       <= done_d;
            mem_rd_o     <= mem_rd_d;
            mem_wr_o     <= mem_wr_d;
            mem_addr_o   <= mem_addr_d;
            mem_wdata_o  <= mem_wdata_d;
            wr_o         <= wr_d;
            rd_o         <= rd_d;
            clause_o     <= clause_d;
            clause_len_o <= clause_len_d;
        end
    end

endmodule

// File: tb/tb_clause_bin_loader.sv
// Bench for clause_bin_loader: table of load/unload transactions plus
// hand sequences for write stalls, ignored starts and mid-load reset.
module tb_clause_bin_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_load_i = 1'b0;
    logic        start_unload_i = 1'b0;
    logic [7:0]  base_addr_i = '0;
    logic [3:0]  num_i = '0;
    logic        busy_o, done_o, mem_rd_o, mem_wr_o;
    logic [7:0]  mem_addr_o;
    logic [19:0] mem_rdata_i = '0;
    logic        mem_rvalid_i = 1'b0;
    logic [19:0] mem_wdata_o;
    logic        mem_wready_i = 1'b0;
    logic [7:0]  wr_o, rd_o;
    logic [15:0] clause_o;
    logic [3:0]  clause_len_o;
    logic [15:0] clause_i = '0;

    always #5 clk = ~clk;

    clause_bin_loader dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_unload_i(start_unload_i),
        .base_addr_i(base_addr_i), .num_i(num_i),
        .busy_o(busy_o), .done_o(done_o),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wready_i(mem_wready_i),
        .wr_o(wr_o), .rd_o(rd_o),
        .clause_o(clause_o), .clause_len_o(clause_len_o),
        .clause_i(clause_i)
    );

    logic [19:0] mem [256];
    logic [19:0] slots [8];
    int stall_cfg = 0;

    int n_reads = 0, n_wr = 0, n_zero = 0, n_rd = 0, n_mw = 0;
    int n_done = 0, n_busy = 0, strobe_bad = 0, busy_bad = 0, stable_bad = 0;
    logic [7:0]  rd_addr_q [$];
    logic [7:0]  mw_addr_q [$];
    logic [19:0] mw_data_q [$];

    int pend = 0, wcnt = 0, wr_k = 0, rd_k = 0;
    logic [7:0]  pend_addr = '0, held_addr = '0;
    logic [19:0] held_data = '0;
    logic        held = 1'b0;

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Memory responder, clause array model and protocol monitor.
    always @(negedge clk) begin
        if (!rst) begin
            pend = 0; wcnt = 0; held = 1'b0; wr_k = 0; rd_k = 0;
            mem_rvalid_i = 1'b0; mem_wready_i = 1'b0;
        end else begin
            if (pend > 0) begin
                pend--;
                mem_rvalid_i = (pend == 0);
                mem_rdata_i  = mem[pend_addr];
            end else mem_rvalid_i = 1'b0;
            if (mem_rd_o) begin
                n_reads++;
                rd_addr_q.push_back(mem_addr_o);
                pend = 2;
                pend_addr = mem_addr_o;
            end
            if (held && (!mem_wr_o || mem_addr_o !== held_addr
                         || mem_wdata_o !== held_data)) stable_bad++;
            held = 1'b0;
            if (mem_wr_o) begin
                if (wcnt < stall_cfg) begin
                    wcnt++;
                    mem_wready_i = 1'b0;
                    held = 1'b1;
                    held_addr = mem_addr_o;
                    held_data = mem_wdata_o;
                end else begin
                    wcnt = 0;
                    mem_wready_i = 1'b1;
                    n_mw++;
                    mw_addr_q.push_back(mem_addr_o);
                    mw_data_q.push_back(mem_wdata_o);
                end
            end else mem_wready_i = 1'b0;
            if (wr_o != 0) begin
                if (wr_o !== 8'(1 << wr_k)) strobe_bad++;
                slots[oh_idx(wr_o)] = {clause_len_o, clause_o};
                n_wr++;
                if (clause_o == 0 && clause_len_o == 0) n_zero++;
                wr_k++;
            end
            if (rd_o != 0) begin
                if (rd_o !== 8'(1 << rd_k)) strobe_bad++;
                clause_i = slots[oh_idx(rd_o)][15:0];
                n_rd++;
                rd_k++;
            end
            if (!$onehot0(wr_o) || !$onehot0(rd_o) || (wr_o != 0 && rd_o != 0))
                strobe_bad++;
            if (busy_o) n_busy++;
            if (done_o) begin
                n_done++;
                if (busy_o) busy_bad++;
                wr_k = 0; rd_k = 0;
            end
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int s_reads, s_wr, s_zero, s_rd, s_mw, s_done, s_busy, s_sb, s_bb, s_st, s_rq, s_mq;

    task automatic snap();
        s_reads = n_reads; s_wr = n_wr; s_zero = n_zero; s_rd = n_rd;
        s_mw = n_mw; s_done = n_done; s_busy = n_busy; s_sb = strobe_bad;
        s_bb = busy_bad; s_st = stable_bad;
        s_rq = rd_addr_q.size(); s_mq = mw_addr_q.size();
    endtask

    task automatic pulse(input int op, input logic [7:0] b, input logic [3:0] nm);
        @(negedge clk);
        base_addr_i = b; num_i = nm;
        start_load_i = (op != 1);
        start_unload_i = (op != 0);
        @(negedge clk);
        start_load_i = 1'b0; start_unload_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int i;
        i = 0;
        while (n_done == s_done && i < 1000) begin
            @(negedge clk);
            i++;
        end
        chk({nm, "_timeout"}, 32'(n_done != s_done), 1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int op; logic [7:0] base; logic [3:0] num; int stall;
        int reads; logic [7:0] a_first; logic [7:0] a_last;
        int wrs; int zeros; int rds; int mws; int busy;
    } vec_t;

    vec_t vt [9];

    initial begin
        vec_t t;
        string p;
        int nn, bad;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            mem[i] = {a[3:0], a, ~a};
        end
        mem[8'h90] = {4'd0, 16'hFFFF};
        mem[8'h91] = {4'd9, 16'h0000};
        mem[8'h92] = {4'd1, 16'h0019};

        // op: 0 load, 1 unload, 2 both starts together
        vt[0] = '{0, 8'h10, 4'd8,  0, 8, 8'h10, 8'h17, 8, 0, 0, 0, 1};
        vt[1] = '{0, 8'h20, 4'd3,  0, 3, 8'h20, 8'h22, 8, 5, 0, 0, 1};
        vt[2] = '{0, 8'hFE, 4'd4,  0, 4, 8'hFE, 8'h01, 8, 4, 0, 0, 1};
        vt[3] = '{0, 8'h40, 4'd12, 0, 8, 8'h40, 8'h47, 8, 0, 0, 0, 1};
        vt[4] = '{2, 8'h30, 4'd2,  0, 2, 8'h30, 8'h31, 8, 6, 0, 0, 1};
        vt[5] = '{1, 8'h80, 4'd2,  1, 0, 8'h80, 8'h81, 0, 0, 2, 2, 1};
        vt[6] = '{1, 8'h00, 4'd0,  0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0};
        vt[7] = '{0, 8'h00, 4'd0,  0, 0, 8'h00, 8'h00, 8, 8, 0, 0, 1};
        vt[8] = '{1, 8'hFF, 4'd12, 0, 0, 8'hFF, 8'h06, 0, 0, 8, 8, 1};

        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(|{busy_o, done_o, mem_rd_o, mem_addr_o, mem_wr_o,
            mem_wdata_o, wr_o, rd_o, clause_o, clause_len_o}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy_o), 0);

        for (int v = 0; v < 9; v++) begin
            t = vt[v];
            p = $sformatf("v%0d", v);
            stall_cfg = t.stall;
            snap();
            pulse(t.op, t.base, t.num);
            wait_done(p);
            chk({p, "_done"}, 32'(n_done - s_done), 1);
            chk({p, "_reads"}, 32'(n_reads - s_reads), 32'(t.reads));
            chk({p, "_wr"}, 32'(n_wr - s_wr), 32'(t.wrs));
            chk({p, "_zero"}, 32'(n_zero - s_zero), 32'(t.zeros));
            chk({p, "_rd"}, 32'(n_rd - s_rd), 32'(t.rds));
            chk({p, "_mw"}, 32'(n_mw - s_mw), 32'(t.mws));
            chk({p, "_busy_seen"}, 32'(n_busy > s_busy), 32'(t.busy));
            chk({p, "_busy_end"}, 32'(busy_o), 0);
            chk({p, "_strobe"}, 32'(strobe_bad - s_sb), 0);
            chk({p, "_busy_at_done"}, 32'(busy_bad - s_bb), 0);
            if (t.reads > 0 && rd_addr_q.size() == s_rq + t.reads) begin
                chk({p, "_a_first"}, 32'(rd_addr_q[s_rq]), 32'(t.a_first));
                chk({p, "_a_last"}, 32'(rd_addr_q[s_rq+t.reads-1]), 32'(t.a_last));
            end
            if (t.mws > 0 && mw_addr_q.size() == s_mq + t.mws) begin
                chk({p, "_w_first"}, 32'(mw_addr_q[s_mq]), 32'(t.a_first));
                chk({p, "_w_last"}, 32'(mw_addr_q[s_mq+t.mws-1]), 32'(t.a_last));
            end
            if (t.op != 1) begin
                nn = (t.num > 8) ? 8 : int'(t.num);
                bad = 0;
                for (int k = 0; k < 8; k++) begin
                    a = t.base + 8'(k);
                    if (slots[k] !== ((k < nn) ? mem[a] : 20'h0)) bad++;
                end
                chk({p, "_slots"}, 32'(bad), 0);
            end
        end

        // Unload recomputes lengths; every write stalls four cycles.
        stall_cfg = 0;
        snap();
        pulse(0, 8'h90, 4'd3);
        wait_done("pre");
        stall_cfg = 4;
        snap();
        pulse(1, 8'h50, 4'd3);
        wait_done("ul");
        chk("ul_mw", 32'(n_mw - s_mw), 3);
        chk("ul_stable", 32'(stable_bad - s_st), 0);
        chk("ul_busy_end", 32'(busy_o), 0);
        if (mw_addr_q.size() == s_mq + 3) begin
            chk("ul_a0", 32'(mw_addr_q[s_mq]), 32'h50);
            chk("ul_d0", 32'(mw_data_q[s_mq]), 32'h8FFFF);
            chk("ul_d1", 32'(mw_data_q[s_mq+1]), 32'h00000);
            chk("ul_a2", 32'(mw_addr_q[s_mq+2]), 32'h52);
            chk("ul_d2", 32'(mw_data_q[s_mq+2]), 32'h30019);
        end
        stall_cfg = 0;

        // Unload start arriving mid-load is dropped.
        snap();
        pulse(0, 8'h60, 4'd2);
        repeat (2) @(negedge clk);
        start_unload_i = 1'b1;
        @(negedge clk);
        start_unload_i = 1'b0;
        wait_done("ign");
        repeat (20) @(negedge clk);
        chk("ign_done", 32'(n_done - s_done), 1);
        chk("ign_rd", 32'(n_rd - s_rd), 0);
        chk("ign_mw", 32'(n_mw - s_mw), 0);
        chk("ign_reads", 32'(n_reads - s_reads), 2);

        // Reset while waiting for read data aborts without done.
        snap();
        pulse(0, 8'h70, 4'd4);
        for (int i = 0; i < 50 && n_reads == s_reads; i++) @(negedge clk);
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy_o), 1);
        rst = 1'b0;
        #1;
        chk("rst_outs", 32'(|{busy_o, done_o, mem_rd_o, mem_addr_o, mem_wr_o,
            mem_wdata_o, wr_o, rd_o, clause_o, clause_len_o}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_no_done", 32'(n_done - s_done), 0);
        chk("rst_no_wr", 32'(n_wr - s_wr), 0);
        snap();
        pulse(0, 8'h70, 4'd4);
        wait_done("rl");
        chk("rl_done", 32'(n_done - s_done), 1);
        chk("rl_reads", 32'(n_reads - s_reads), 4);
        chk("rl_wr", 32'(n_wr - s_wr), 8);
        chk("rl_strobe", 32'(strobe_bad - s_sb), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
